// File: rtl/conv2d_pkg.sv
// Shared definitions for the Conv2D3x3 datapath: default size limits, the
// counter widths derived from them, and the 3x3 tap index helper.
package conv2d_pkg;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_MAX_IMG_WIDTH  = 128;
  localparam int DEF_MAX_TRANSFERS  = 512;
  localparam int DEF_MAX_LINE_DEPTH = 8192;

  // Counter widths for the default limits
  localparam int T_CNT_W     = $clog2(DEF_MAX_TRANSFERS);
  localparam int COL_CNT_W   = $clog2(DEF_MAX_IMG_WIDTH + 1);
  localparam int LINE_ADDR_W = $clog2(DEF_MAX_LINE_DEPTH);
  localparam int ROW_CNT_W   = 16;

  // Flat tap index of window element (r,c); r=0 oldest row, c=0 oldest column
  function automatic int win_idx(input int r, input int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Stream/control bundle between the controller and conv_window_gen.
// tvalid is a pure strobe: a beat is consumed in every cycle it is high and
// there is no back-pressure; the controller paces itself with the position
// flags (next_window_valid, last_data, last_window, pad_beat), which describe
// the position the next strobe will consume. load_param wins over tvalid.
interface conv_window_gen_if #(
  parameter int DATA_WIDTH = 32
) (
  input logic clk
);
  logic                    load_param;
  logic [15:0]             width;
  logic [15:0]             height;
  logic [15:0]             transfers;
  logic                    pad;
  logic                    tvalid;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [9*DATA_WIDTH-1:0] window;
  logic                    next_window_valid;
  logic                    last_data;
  logic                    last_window;
  logic                    pad_beat;

  modport master (
    input  clk,
    output load_param, width, height, transfers, pad, tvalid, tdata,
    input  window, next_window_valid, last_data, last_window, pad_beat
  );

  modport slave (
    input  clk,
    input  load_param, width, height, transfers, pad, tvalid, tdata,
    output window, next_window_valid, last_data, last_window, pad_beat
  );
endinterface

// File: rtl/var_delay_line.sv
// Variable-length delay line: o_dout presents the i_din value accepted i_len
// advances earlier. Circular buffer of length i_len with a registered read;
// the read address is pre-advanced on each advance so the delayed word is
// already in the output register when the next advance arrives. A length of
// one reads back the word being written, so that case bypasses the memory.
module var_delay_line #(
  parameter int  DEPTH = 512,
  parameter int  WIDTH = 32,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LENW  = $clog2(DEPTH + 1)
) (
  input  logic             i_aclk,
  input  logic             i_aresetn,
  input  logic             i_clr,
  input  logic             i_adv,
  input  logic [LENW-1:0]  i_len,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             wrap;

  assign wrap    = (LENW'(ptr_q) + LENW'(1)) >= i_len;
  assign rd_addr = wrap ? '0 : ptr_q + AW'(1);
  assign o_dout  = dout_q;

  // Storage write at the current pointer; contents are never reset
  always_ff @(posedge i_aclk) begin
    if (i_adv && !i_clr) begin
      mem_q[ptr_q] <= i_din;
    end
  end

  // Pointer advance and pre-fetch of the word needed at the next advance
  always_comb begin
    ptr_d  = ptr_q;
    dout_d = dout_q;
    if (i_clr) begin
      ptr_d = '0;
    end else if (i_adv) begin
      ptr_d  = rd_addr;
      dout_d = (rd_addr == ptr_q) ? i_din : mem_q[rd_addr];
    end
  end

  // Pointer and read register
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      ptr_q  <= '0;
      dout_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      dout_q <= dout_d;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Sliding 3x3 window generator. Walks t/col/row position counters on each
// strobe, feeds the beat (zeroed on pad positions) through two line delays
// and six column delays, and registers the 3x3 window of the accepted beat's
// channel. Flags are decoded from the counters and latched parameters only.
// Build option CONV_WIN_PAD_EN enables zero-pad (same-size) mode; without it
// i_pad is ignored, o_pad_beat is 0 and no border masking is built.
module conv_window_gen
  import conv2d_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int MAX_IMG_WIDTH  = DEF_MAX_IMG_WIDTH,
  parameter int MAX_TRANSFERS  = DEF_MAX_TRANSFERS,
  parameter int MAX_LINE_DEPTH = DEF_MAX_LINE_DEPTH
) (
  input  logic                    i_aclk,
  input  logic                    i_aresetn,
  input  logic                    i_load_param,
  input  logic [15:0]             i_width,
  input  logic [15:0]             i_height,
  input  logic [15:0]             i_transfers,
  input  logic                    i_pad,
  input  logic                    i_tvalid,
  input  logic [DATA_WIDTH-1:0]   i_tdata,
  output logic [9*DATA_WIDTH-1:0] o_window,
  output logic                    o_next_window_valid,
  output logic                    o_last_data,
  output logic                    o_last_window,
  output logic                    o_pad_beat
);

  localparam int T_W    = $clog2(MAX_TRANSFERS);
  localparam int COL_W  = $clog2(MAX_IMG_WIDTH + 1);
  localparam int ROW_W  = ROW_CNT_W;
  localparam int TLEN_W = $clog2(MAX_TRANSFERS + 1);
  localparam int LLEN_W = $clog2(MAX_LINE_DEPTH + 1);
  localparam int DW     = DATA_WIDTH;

  logic [15:0]       w_q, w_d, h_q, h_d, tn_q, tn_d;
  logic [T_W-1:0]    t_q, t_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [9*DW-1:0]   window_q, window_d;

  logic              pad_on;
  logic              adv;
  logic [15:0]       t_ext, col_ext, cw, rh;
  logic              at_t_last, at_col_last, at_row_last;
  logic              pad_beat;
  logic [DW-1:0]     beat_x;
  logic [LLEN_W-1:0] line_len;
  logic [DW-1:0]     row_tap [3];
  logic [DW-1:0]     c1_tap  [3];
  logic [DW-1:0]     c0_tap  [3];

`ifdef CONV_WIN_PAD_EN
  logic pad_q, pad_d;
  assign pad_on = pad_q;

  // Pad mode is captured with the other image parameters
  always_comb begin
    pad_d = pad_q;
    if (i_load_param) pad_d = i_pad;
  end

  // Pad mode register
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) pad_q <= 1'b0;
    else            pad_q <= pad_d;
  end

  assign pad_beat = pad_q && ((row_q == h_q) || (col_ext == w_q));
`else
  logic unused_pad;
  assign unused_pad = i_pad;
  assign pad_on     = 1'b0;
  assign pad_beat   = 1'b0;
`endif

  // A load drops any simultaneous beat
  assign adv = i_tvalid && !i_load_param;

  assign t_ext   = 16'(t_q);
  assign col_ext = 16'(col_q);
  assign cw      = w_q + {15'd0, pad_on};
  assign rh      = h_q + {15'd0, pad_on};

  assign at_t_last   = (t_ext == tn_q - 16'd1);
  assign at_col_last = (col_ext == cw - 16'd1);
  assign at_row_last = (row_q == rh - 16'd1);

  assign o_pad_beat          = pad_beat;
  assign o_last_window       = at_t_last && at_col_last && at_row_last;
  assign o_last_data         = at_t_last && (col_ext == w_q - 16'd1) && (row_q == h_q - 16'd1);
  assign o_next_window_valid = pad_on ? ((row_q >= 16'd1) && (col_ext >= 16'd1))
                                      : ((row_q >= 16'd2) && (col_ext >= 16'd2));
  assign o_window            = window_q;

  // Pad positions carry no stream data; they enter the history as zero
  assign beat_x   = pad_beat ? '0 : i_tdata;
  assign line_len = LLEN_W'(cw * tn_q);

  // Row taps: newest row is the beat itself, older rows come from line delays
  assign row_tap[2] = beat_x;

  var_delay_line #(.DEPTH(MAX_LINE_DEPTH), .WIDTH(DW)) u_line1 (
    .i_aclk   (i_aclk),
    .i_aresetn(i_aresetn),
    .i_clr    (i_load_param),
    .i_adv    (adv),
    .i_len    (line_len),
    .i_din    (row_tap[2]),
    .o_dout   (row_tap[1])
  );

  var_delay_line #(.DEPTH(MAX_LINE_DEPTH), .WIDTH(DW)) u_line0 (
    .i_aclk   (i_aclk),
    .i_aresetn(i_aresetn),
    .i_clr    (i_load_param),
    .i_adv    (adv),
    .i_len    (line_len),
    .i_din    (row_tap[1]),
    .o_dout   (row_tap[0])
  );

  // Column taps: each row tap delayed by one and two pixels (T beats each)
  for (genvar r = 0; r < 3; r++) begin : g_col
    var_delay_line #(.DEPTH(MAX_TRANSFERS), .WIDTH(DW)) u_c1 (
      .i_aclk   (i_aclk),
      .i_aresetn(i_aresetn),
      .i_clr    (i_load_param),
      .i_adv    (adv),
      .i_len    (TLEN_W'(tn_q)),
      .i_din    (row_tap[r]),
      .o_dout   (c1_tap[r])
    );

    var_delay_line #(.DEPTH(MAX_TRANSFERS), .WIDTH(DW)) u_c0 (
      .i_aclk   (i_aclk),
      .i_aresetn(i_aresetn),
      .i_clr    (i_load_param),
      .i_adv    (adv),
      .i_len    (TLEN_W'(tn_q)),
      .i_din    (c1_tap[r]),
      .o_dout   (c0_tap[r])
    );
  end

  // Parameter latch on load
  always_comb begin
    w_d  = w_q;
    h_d  = h_q;
    tn_d = tn_q;
    if (i_load_param) begin
      w_d  = i_width;
      h_d  = i_height;
      tn_d = i_transfers;
    end
  end

  // Position counters: t fastest, then col, then row; wrap after last window
  always_comb begin
    t_d   = t_q;
    col_d = col_q;
    row_d = row_q;
    if (i_load_param) begin
      t_d   = '0;
      col_d = '0;
      row_d = '0;
    end else if (i_tvalid) begin
      if (!at_t_last) begin
        t_d = t_q + T_W'(1);
      end else begin
        t_d = '0;
        if (!at_col_last) begin
          col_d = col_q + COL_W'(1);
        end else begin
          col_d = '0;
          row_d = at_row_last ? '0 : row_q + ROW_W'(1);
        end
      end
    end
  end

  // Window capture on each accepted beat, with border masking in pad mode
  always_comb begin
    window_d = window_q;
    if (adv) begin
      for (int r = 0; r < 3; r++) begin
        window_d[win_idx(r, 2)*DW +: DW] = row_tap[r];
        window_d[win_idx(r, 1)*DW +: DW] = c1_tap[r];
        window_d[win_idx(r, 0)*DW +: DW] = c0_tap[r];
      end
`ifdef CONV_WIN_PAD_EN
      // Top pad row: oldest row would be history from before this image
      if (pad_q && (row_q == 16'd1)) begin
        for (int c = 0; c < 3; c++) window_d[win_idx(0, c)*DW +: DW] = '0;
      end
      // Left pad column: oldest column would wrap into the previous row
      if (pad_q && (col_ext == 16'd1)) begin
        for (int r = 0; r < 3; r++) window_d[win_idx(r, 0)*DW +: DW] = '0;
      end
`endif
    end
  end

  // Parameter, counter and window registers
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      w_q      <= '0;
      h_q      <= '0;
      tn_q     <= 16'd1;
      t_q      <= '0;
      col_q    <= '0;
      row_q    <= '0;
      window_q <= '0;
    end else begin
      w_q      <= w_d;
      h_q      <= h_d;
      tn_q     <= tn_d;
      t_q      <= t_d;
      col_q    <= col_d;
      row_q    <= row_d;
      window_q <= window_d;
    end
  end

endmodule
